// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the stage_fetch_q fetch stage.
//   XLEN / INSN_W      : address and instruction widths (32).
//   RESET_PC_DEFAULT   : default PC loaded on reset.
//   fetch_entry_t      : one prefetch queue entry {pc, insn}.
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INSN_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/stage_fetch_q_if.sv
// stage_fetch_q_if: bundle of the fetch stage's redirect, memory and decode
// signals.
//   master : the fetch stage (drives fe_req/fe_addr and the decode head).
//   slave  : the surrounding pipeline / memory model.
// Signals: fe_enable, pc_wen, pc_in (redirect side); fe_req, fe_addr, fe_ack,
// fe_data (memory side); de_stall, de_valid, de_insn, de_pc, fifo_level
// (decode side). With FETCH_PERF_EN defined the perf_* counters are added.
interface stage_fetch_q_if
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              fe_enable;
  logic              pc_wen;
  logic [XLEN-1:0]   pc_in;
  logic              fe_req;
  logic [XLEN-1:0]   fe_addr;
  logic              fe_ack;
  logic [INSN_W-1:0] fe_data;
  logic              de_stall;
  logic              de_valid;
  logic [INSN_W-1:0] de_insn;
  logic [XLEN-1:0]   de_pc;
  logic [LVL_W-1:0]  fifo_level;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetches;
  logic [31:0]       perf_flushes;
  logic [31:0]       perf_full_cycles;
`endif

  modport master (
    input  fe_enable, pc_wen, pc_in, fe_ack, fe_data, de_stall,
    output fe_req, fe_addr, de_valid, de_insn, de_pc, fifo_level
`ifdef FETCH_PERF_EN
    , output perf_fetches, perf_flushes, perf_full_cycles
`endif
  );

  modport slave (
    output fe_enable, pc_wen, pc_in, fe_ack, fe_data, de_stall,
    input  fe_req, fe_addr, de_valid, de_insn, de_pc, fifo_level
`ifdef FETCH_PERF_EN
    , input perf_fetches, perf_flushes, perf_full_cycles
`endif
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with asynchronous reset.
//   clk, rst      : clock, async active-high reset.
//   push_i        : write push_data_i at the tail.
//   push_data_i   : entry to write.
//   pop_i         : advance the head (ignored when empty).
//   flush_i       : discard all entries; wins over pop, push lands afterwards.
//   head_o        : head entry, zero when empty.
//   level_o       : occupancy 0..DEPTH.
//   empty_o       : level_o == 0.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [LVL_W-1:0] lvl_mid;
  logic             push_ok;

  // Flush/pop are resolved first; the push is then checked against the
  // resulting occupancy so a push into a just-flushed queue is never dropped.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    lvl_mid = lvl_q;
    if (flush_i) begin
      rd_d    = wr_q;
      lvl_mid = '0;
    end else if (pop_i && (lvl_q != '0)) begin
      rd_d    = rd_q + 1'b1;
      lvl_mid = lvl_q - 1'b1;
    end
    push_ok = push_i && (lvl_mid < LVL_W'(DEPTH));
    lvl_d   = lvl_mid;
    if (push_ok) begin
      wr_d  = wr_q + 1'b1;
      lvl_d = lvl_mid + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: the head is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/stage_fetch_q.sv
// stage_fetch_q: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues single-beat fetches while the queue has room (independent of decode
// stalls) and flushes/restarts on a redirect.
//   clk, reset : clock, async active-high reset (sync release).
//   bus        : stage_fetch_q_if.master (redirect, memory and decode signals).
// Optional: define FETCH_PERF_EN to add perf_fetches, perf_flushes and
// perf_full_cycles (32-bit saturating counters).
module stage_fetch_q
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  stage_fetch_q_if.master bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  cur_pc;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             req;
  logic             accept;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign cur_pc = bus.pc_wen ? {bus.pc_in[XLEN-1:2], 2'b00} : pc_q;
  assign req    = bus.fe_enable & ~reset & (level < LVL_W'(DEPTH));
  assign accept = req & bus.fe_ack;
  assign pop    = ~empty & ~bus.de_stall;

  // Without a redirect cur_pc is pc_q, so this also holds pc while idle.
  assign pc_d = accept ? cur_pc + 32'd4 : cur_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign push_entry = '{pc: cur_pc, insn: bus.fe_data};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (reset),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.pc_wen),
    .head_o      (head),
    .level_o     (level),
    .empty_o     (empty)
  );

  assign bus.fe_req     = req;
  assign bus.fe_addr    = cur_pc;
  assign bus.de_valid   = ~empty;
  assign bus.de_insn    = head.insn;
  assign bus.de_pc      = head.pc;
  assign bus.fifo_level = level;

`ifdef FETCH_PERF_EN
  logic [31:0] fetches_q, fetches_d;
  logic [31:0] flushes_q, flushes_d;
  logic [31:0] full_q, full_d;

  always_comb begin
    fetches_d = fetches_q;
    flushes_d = flushes_q;
    full_d    = full_q;
    if (accept && (fetches_q != '1))                         fetches_d = fetches_q + 1'b1;
    if (bus.pc_wen && !empty && (flushes_q != '1))           flushes_d = flushes_q + 1'b1;
    if (bus.fe_enable && (level == LVL_W'(DEPTH)) && (full_q != '1)) full_d = full_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetches_q <= '0;
      flushes_q <= '0;
      full_q    <= '0;
    end else begin
      fetches_q <= fetches_d;
      flushes_q <= flushes_d;
      full_q    <= full_d;
    end
  end

  assign bus.perf_fetches     = fetches_q;
  assign bus.perf_flushes     = flushes_q;
  assign bus.perf_full_cycles = full_q;
`endif

endmodule

// File: tb/tb_stage_fetch_q.sv
// tb_stage_fetch_q: self-checking bench for stage_fetch_q. Directed scenarios
// check against fixed expected values; a randomized run checks against a
// queue-based reference model of the fetch stage.
module tb_stage_fetch_q;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] XK  = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_fetch_q_if #(.DEPTH(DEPTH)) bus ();

  stage_fetch_q #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]  m_pc;
  fetch_entry_t m_q[$];
  logic [31:0]  m_cur;
  bit           m_req;
  logic [31:0]  m_fetches, m_flushes, m_full;

  task automatic model_reset();
    m_pc = RPC;
    m_q.delete();
    m_fetches = 0;
    m_flushes = 0;
    m_full    = 0;
  endtask

  // Apply inputs and compute the model's view of this cycle.
  task automatic drive(input bit en, input bit wen, input logic [31:0] pin,
                       input bit ack, input logic [31:0] data, input bit stall);
    bus.fe_enable = en;
    bus.pc_wen    = wen;
    bus.pc_in     = pin;
    bus.fe_ack    = ack;
    bus.fe_data   = data;
    bus.de_stall  = stall;
    m_cur = wen ? {pin[31:2], 2'b00} : m_pc;
    m_req = en && (m_q.size() < DEPTH);
    #1;
  endtask

  // Advance the model by one edge with the currently applied inputs.
  task automatic tick();
    bit pop, acc;
    pop = (m_q.size() != 0) && !bus.de_stall;
    acc = m_req && bus.fe_ack;
    if (acc && m_fetches != 32'hFFFF_FFFF) m_fetches++;
    if (bus.pc_wen && m_q.size() != 0 && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    if (bus.fe_enable && m_q.size() == DEPTH && m_full != 32'hFFFF_FFFF) m_full++;
    if (bus.pc_wen) m_q.delete();
    else if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back('{pc: m_cur, insn: bus.fe_data});
      m_pc = m_cur + 32'd4;
    end else if (bus.pc_wen) begin
      m_pc = m_cur;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 0, 1, 0, 0);
    checks++; if (bus.fe_req !== 1'b0) begin errors++; $display("FAIL reset_fe_req got %0b want 0", bus.fe_req); end
    checks++; if (bus.de_valid !== 1'b0) begin errors++; $display("FAIL reset_de_valid got %0b want 0", bus.de_valid); end
    checks++; if (bus.fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level); end
    checks++; if (bus.de_pc !== 32'h0 || bus.de_insn !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", bus.de_pc, bus.de_insn); end
    checks++; if (bus.fe_addr !== RPC) begin errors++; $display("FAIL reset_fe_addr got %h want %h", bus.fe_addr, RPC); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = RPC + 32'(4 * i);
      drive(1, 0, 0, 1, a ^ XK, 0);
      checks++; if (bus.fe_addr !== a || bus.fe_req !== 1'b1) begin errors++; $display("FAIL stream_addr[%0d] got %h req %0b want %h req 1", i, bus.fe_addr, bus.fe_req, a); end
      checks++; if (bus.de_valid !== (i != 0)) begin errors++; $display("FAIL stream_valid[%0d] got %0b want %0b", i, bus.de_valid, i != 0); end
      if (i != 0) begin
        checks++; if (bus.de_pc !== a - 4 || bus.de_insn !== ((a - 4) ^ XK)) begin errors++; $display("FAIL stream_head[%0d] got %h/%h want %h/%h", i, bus.de_pc, bus.de_insn, a - 4, (a - 4) ^ XK); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_full();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a = RPC + 32'(4 * i);
      drive(1, 0, 0, 1, a ^ XK, 1);
      checks++; if (bus.fe_req !== (i < DEPTH)) begin errors++; $display("FAIL full_req[%0d] got %0b want %0b", i, bus.fe_req, i < DEPTH); end
      checks++; if (bus.fifo_level !== LVL_W'(i < DEPTH ? i : DEPTH)) begin errors++; $display("FAIL full_level[%0d] got %0d want %0d", i, bus.fifo_level, i < DEPTH ? i : DEPTH); end
      tick();
    end
    for (int k = 0; k < DEPTH; k++) begin
      a = RPC + 32'(4 * k);
      drive(1, 0, 0, 0, 0, 0);
      checks++; if (bus.de_pc !== a || bus.de_insn !== (a ^ XK)) begin errors++; $display("FAIL full_drain[%0d] got %h/%h want %h/%h", k, bus.de_pc, bus.de_insn, a, a ^ XK); end
      checks++; if (bus.fe_req !== (k != 0)) begin errors++; $display("FAIL full_req_return[%0d] got %0b want %0b", k, bus.fe_req, k != 0); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.fifo_level !== '0 || bus.de_valid !== 1'b0) begin errors++; $display("FAIL full_empty got level %0d valid %0b want 0/0", bus.fifo_level, bus.de_valid); end
    tick();
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, (RPC + 32'(4 * i)) ^ XK, 1);
      tick();
    end
    drive(1, 1, 32'h8000_1002, 1, 32'h8000_1000 ^ XK, 0);
    checks++; if (bus.fe_addr !== 32'h8000_1000 || bus.fifo_level !== LVL_W'(3)) begin errors++; $display("FAIL redir_pre got addr %h level %0d want 80001000/3", bus.fe_addr, bus.fifo_level); end
    tick();
    drive(1, 0, 0, 0, 0, 1);
    checks++; if (bus.fifo_level !== LVL_W'(1)) begin errors++; $display("FAIL redir_level got %0d want 1", bus.fifo_level); end
    checks++; if (bus.de_pc !== 32'h8000_1000 || bus.de_insn !== (32'h8000_1000 ^ XK)) begin errors++; $display("FAIL redir_head got %h/%h want 80001000/%h", bus.de_pc, bus.de_insn, 32'h8000_1000 ^ XK); end
    checks++; if (bus.fe_addr !== 32'h8000_1004) begin errors++; $display("FAIL redir_next_addr got %h want 80001004", bus.fe_addr); end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 1, (RPC + 32'(4 * i)) ^ XK, 1);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      a = RPC + 32'(4 * i);
      drive(1, 0, 0, 1, (a + 32'd8) ^ XK, 0);
      checks++; if (bus.fifo_level !== LVL_W'(2)) begin errors++; $display("FAIL b2b_level[%0d] got %0d want 2", i, bus.fifo_level); end
      checks++; if (bus.de_pc !== a || bus.de_insn !== (a ^ XK)) begin errors++; $display("FAIL b2b_head[%0d] got %h/%h want %h/%h", i, bus.de_pc, bus.de_insn, a, a ^ XK); end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC ^ XK, 0);
    checks++; if (bus.fe_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffc", bus.fe_addr); end
    tick();
    drive(1, 0, 0, 1, 32'h0 ^ XK, 0);
    checks++; if (bus.fe_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 00000000", bus.fe_addr); end
    checks++; if (bus.de_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head0 got %h want fffffffc", bus.de_pc); end
    tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (bus.de_pc !== 32'h0 || bus.de_insn !== XK || bus.fifo_level !== LVL_W'(1)) begin errors++; $display("FAIL wrap_head1 got %h/%h level %0d want 00000000/%h/1", bus.de_pc, bus.de_insn, bus.fifo_level, XK); end
    tick();
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, (RPC + 32'(4 * i)) ^ XK, 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 1);
    checks++; if (bus.fifo_level !== LVL_W'(3)) begin errors++; $display("FAIL areset_pre_level got %0d want 3", bus.fifo_level); end
    reset = 1'b1;
    #1;
    checks++; if (bus.de_valid !== 1'b0 || bus.fifo_level !== '0) begin errors++; $display("FAIL areset_immediate got valid %0b level %0d want 0/0", bus.de_valid, bus.fifo_level); end
`ifdef FETCH_PERF_EN
    checks++; if (bus.perf_fetches !== 0 || bus.perf_flushes !== 0 || bus.perf_full_cycles !== 0) begin errors++; $display("FAIL areset_perf got %0d/%0d/%0d want 0/0/0", bus.perf_fetches, bus.perf_flushes, bus.perf_full_cycles); end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (bus.fe_addr !== RPC || bus.fe_req !== 1'b1) begin errors++; $display("FAIL areset_release got addr %h req %0b want %h/1", bus.fe_addr, bus.fe_req, RPC); end
    tick();
  endtask

  task automatic test_random();
    bit en, wen, ack, stall;
    logic [31:0] pin, data;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en    = ($urandom_range(0, 9) < 8);
      wen   = ($urandom_range(0, 19) == 0);
      ack   = ($urandom_range(0, 9) < 7);
      stall = ($urandom_range(0, 9) < 5);
      pin   = $urandom;
      data  = $urandom;
      drive(en, wen, pin, ack, data, stall);
      checks++; if (bus.fe_req !== m_req || bus.fe_addr !== m_cur) begin errors++; $display("FAIL rnd_req[%0d] got %0b/%h want %0b/%h", c, bus.fe_req, bus.fe_addr, m_req, m_cur); end
      checks++; if (bus.fifo_level !== LVL_W'(m_q.size()) || bus.de_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_level[%0d] got %0d/%0b want %0d", c, bus.fifo_level, bus.de_valid, m_q.size()); end
      if (m_q.size() != 0) begin
        checks++; if (bus.de_pc !== m_q[0].pc || bus.de_insn !== m_q[0].insn) begin errors++; $display("FAIL rnd_head[%0d] got %h/%h want %h/%h", c, bus.de_pc, bus.de_insn, m_q[0].pc, m_q[0].insn); end
      end
      tick();
    end
`ifdef FETCH_PERF_EN
    drive(0, 0, 0, 0, 0, 1);
    checks++; if (bus.perf_fetches !== m_fetches || bus.perf_flushes !== m_flushes || bus.perf_full_cycles !== m_full) begin errors++; $display("FAIL rnd_perf got %0d/%0d/%0d want %0d/%0d/%0d", bus.perf_fetches, bus.perf_flushes, bus.perf_full_cycles, m_fetches, m_flushes, m_full); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
